// File: rtl/wb_host_initiator_pkg.sv
// Shared types and constants for the Wishbone host initiator.
// Bus widths, the default ack timeout, and the transfer FSM states.
package wb_host_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    localparam int WB_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_host_state_t;

endpackage

// File: rtl/wb_host_initiator_if.sv
// Host command/response handshake plus Wishbone master signals.
// The master modport is the initiator's view; slave is the host/slave environment.
interface wb_host_initiator_if;
    import wb_host_pkg::*;

    logic               cmd_valid_i;
    logic               cmd_ready_o;
    logic               cmd_we_i;
    logic [WB_AW-1:0]   cmd_adr_i;
    logic [WB_DW-1:0]   cmd_dat_i;
    logic [WB_SW-1:0]   cmd_sel_i;

    logic               rsp_valid_o;
    logic               rsp_ready_i;
    logic [WB_DW-1:0]   rsp_dat_o;
    logic               rsp_timeout_o;

    logic               wbm_cyc_o;
    logic               wbm_stb_o;
    logic               wbm_we_o;
    logic [WB_AW-1:0]   wbm_adr_o;
    logic [WB_DW-1:0]   wbm_dat_o;
    logic [WB_SW-1:0]   wbm_sel_o;
    logic [WB_DW-1:0]   wbm_dat_i;
    logic               wbm_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_timeout_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_timeout_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_dat_i, wbm_ack_i
    );

endinterface

// File: rtl/wb_host_initiator.sv
// Wishbone classic single-transfer initiator with an ack timeout.
// One command in flight: accept, run one cyc/stb cycle, present one response.
module wb_host_initiator
    import wb_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT,
    parameter int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    wb_host_initiator_if.master  bus
);

    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    wb_host_state_t     r_state;
    logic [TW-1:0]      r_cnt;
    logic               r_cmd_ready;
    logic               r_cyc;
    logic               r_we;
    logic [WB_AW-1:0]   r_adr;
    logic [WB_DW-1:0]   r_dat;
    logic [WB_SW-1:0]   r_sel;
    logic               r_rsp_valid;
    logic [WB_DW-1:0]   r_rsp_dat;
    logic               r_rsp_timeout;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b1;
            r_cyc         <= 1'b0;
            r_we          <= 1'b0;
            r_adr         <= '0;
            r_dat         <= '0;
            r_sel         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_dat     <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid_i) begin
                        r_we        <= bus.cmd_we_i;
                        r_adr       <= bus.cmd_adr_i;
                        r_dat       <= bus.cmd_dat_i;
                        r_sel       <= bus.cmd_sel_i;
                        r_cyc       <= 1'b1;
                        r_cnt       <= '0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= BUS;
                    end
                end
                BUS: begin
                    // Ack is checked first so it wins over a same-cycle expiry.
                    if (bus.wbm_ack_i) begin
                        r_rsp_dat     <= r_we ? '0 : bus.wbm_dat_i;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_cyc         <= 1'b0;
                        r_state       <= RESP;
                    end else if (r_cnt == TO_MAX) begin
                        r_rsp_dat     <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_cyc         <= 1'b0;
                        r_state       <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_cyc       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // cyc and stb share one register: classic single transfers only.
    assign bus.cmd_ready_o   = r_cmd_ready;
    assign bus.wbm_cyc_o     = r_cyc;
    assign bus.wbm_stb_o     = r_cyc;
    assign bus.wbm_we_o      = r_we;
    assign bus.wbm_adr_o     = r_adr;
    assign bus.wbm_dat_o     = r_dat;
    assign bus.wbm_sel_o     = r_sel;
    assign bus.rsp_valid_o   = r_rsp_valid;
    assign bus.rsp_dat_o     = r_rsp_dat;
    assign bus.rsp_timeout_o = r_rsp_timeout;

endmodule

// File: tb/tb_wb_host_initiator.sv
// Scoreboard bench for wb_host_initiator with TIMEOUT_CYCLES=8 and a
// configurable wait-state Wishbone slave model.
module tb_wb_host_initiator;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_host_initiator_if bus();

    wb_host_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          len;
    } xfer_t;

    typedef struct {
        logic [31:0] dat;
        logic        to;
    } rsp_t;

    xfer_t xq[$];
    rsp_t  rq[$];

    int n_checks = 0;
    int n_pass   = 0;

    int          slv_wait  = 0;
    bit          slv_never = 1'b0;
    bit          slv_stray = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          bcnt      = 0;

    // Slave model: ack after slv_wait wait cycles; bcnt counts edges seen with cyc high.
    assign bus.wbm_ack_i = (bus.wbm_cyc_o && bus.wbm_stb_o && !slv_never && (bcnt == slv_wait))
                           || slv_stray;
    assign bus.wbm_dat_i = slv_rdata;

    always @(posedge clk) begin
        bcnt <= bus.wbm_cyc_o ? bcnt + 1 : 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Bus and response monitor, sampled on the falling edge.
    initial begin
        int   run_len;
        rsp_t r;
        run_len = 0;
        forever begin
            @(negedge clk);
            if (bus.wbm_cyc_o) begin
                chk("cyc_expected", 32'(xq.size() != 0), 1);
                if (xq.size() != 0) begin
                    chk("wbm_stb", 32'(bus.wbm_stb_o), 1);
                    chk("wbm_we", 32'(bus.wbm_we_o), 32'(xq[0].we));
                    chk("wbm_adr", bus.wbm_adr_o, xq[0].adr);
                    chk("wbm_dat", bus.wbm_dat_o, xq[0].dat);
                    chk("wbm_sel", 32'(bus.wbm_sel_o), 32'(xq[0].sel));
                end
                run_len++;
            end else if (run_len > 0) begin
                if (xq.size() != 0) begin
                    chk("cyc_len", run_len, xq[0].len);
                    void'(xq.pop_front());
                end
                run_len = 0;
            end
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                chk("rsp_expected", 32'(rq.size() != 0), 1);
                if (rq.size() != 0) begin
                    r = rq.pop_front();
                    chk("rsp_dat", bus.rsp_dat_o, r.dat);
                    chk("rsp_timeout", 32'(bus.rsp_timeout_o), 32'(r.to));
                    $display("rsp dat=%h timeout=%0d (expected %h/%0d)",
                             bus.rsp_dat_o, bus.rsp_timeout_o, r.dat, r.to);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int wt, input bit never,
                         input logic [31:0] rdata, input int len,
                         input logic [31:0] edat, input logic eto);
        int k;
        slv_wait  = wt;
        slv_never = never;
        slv_rdata = rdata;
        xq.push_back('{we, adr, dat, sel, len});
        rq.push_back('{edat, eto});
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        bus.cmd_sel_i   = sel;
        k = 0;
        while (!bus.cmd_ready_o && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("accept_bound", 32'(k < 50), 1);
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_adr_i   = $urandom;
        bus.cmd_dat_i   = $urandom;
        bus.cmd_we_i    = ~we;
        chk("cmd_ready_busy", 32'(bus.cmd_ready_o), 0);
        k = 0;
        while (!bus.rsp_valid_o && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rsp_latency", k, len);
    endtask

    task automatic finish(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.rsp_valid_o), 1);
            if (rq.size() != 0) begin
                chk("hold_dat", bus.rsp_dat_o, rq[0].dat);
                chk("hold_timeout", 32'(bus.rsp_timeout_o), 32'(rq[0].to));
            end
            chk("hold_cmd_ready", 32'(bus.cmd_ready_o), 0);
            chk("hold_cyc", 32'(bus.wbm_cyc_o), 0);
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
        chk("rsp_valid_drop", 32'(bus.rsp_valid_o), 0);
        chk("cmd_ready_back", 32'(bus.cmd_ready_o), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        int          wt;
        int          len;
        logic        eto;
        logic [31:0] rd;
        logic [31:0] edat;

        rst_n           = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = '0;
        bus.cmd_dat_i   = '0;
        bus.cmd_sel_i   = '0;
        bus.rsp_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", 32'(bus.wbm_cyc_o), 0);
        chk("rst_stb", 32'(bus.wbm_stb_o), 0);
        chk("rst_we", 32'(bus.wbm_we_o), 0);
        chk("rst_adr", bus.wbm_adr_o, 0);
        chk("rst_dat", bus.wbm_dat_o, 0);
        chk("rst_sel", 32'(bus.wbm_sel_o), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("rst_rsp_dat", bus.rsp_dat_o, 0);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout_o), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 1);

        // Zero-wait write; read data on the bus must not leak into the response.
        issue(1'b1, 32'h3000_0000, 32'h0000_00A5, 4'hF, 0, 1'b0, 32'h1234_5678, 1, 32'h0, 1'b0);
        finish(0);
        chk("idle_keep_adr", bus.wbm_adr_o, 32'h3000_0000);
        chk("idle_keep_we", 32'(bus.wbm_we_o), 1);
        chk("idle_keep_sel", 32'(bus.wbm_sel_o), 32'hF);

        // Read with 3 wait states.
        issue(1'b0, 32'h3000_0004, 32'h0, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, 4, 32'hDEAD_BEEF, 1'b0);
        finish(0);

        // Slave never acks: timeout after TO+1 cycles, then a normal transfer.
        issue(1'b0, 32'h3000_0008, 32'h0, 4'h3, 0, 1'b1, 32'hFFFF_FFFF, TO + 1, 32'h0, 1'b1);
        finish(0);
        issue(1'b0, 32'h3000_000C, 32'h0, 4'hC, 0, 1'b0, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 1'b0);
        finish(0);

        // Ack on the expiry cycle wins; one cycle earlier is plainly normal.
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF, TO, 1'b0, 32'hCAFE_0001, TO + 1, 32'hCAFE_0001, 1'b0);
        finish(0);
        issue(1'b0, 32'h3000_0014, 32'h0, 4'h1, TO - 1, 1'b0, 32'hCAFE_0002, TO, 32'hCAFE_0002, 1'b0);
        finish(0);

        // Response back-pressure with a second command waiting.
        issue(1'b1, 32'h3000_0020, 32'h5555_AAAA, 4'h6, 1, 1'b0, 32'h7777_7777, 2, 32'h0, 1'b0);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = 32'h3000_0024;
        bus.cmd_sel_i   = 4'hF;
        finish(5);
        issue(1'b0, 32'h3000_0024, 32'h0, 4'hF, 2, 1'b0, 32'hA5A5_0024, 3, 32'hA5A5_0024, 1'b0);
        finish(0);

        // Reset in the second BUS cycle abandons the transfer with no response.
        slv_never = 1'b1;
        xq.push_back('{1'b1, 32'h3000_0030, 32'h1111_2222, 4'hF, 2});
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b1;
        bus.cmd_adr_i   = 32'h3000_0030;
        bus.cmd_dat_i   = 32'h1111_2222;
        bus.cmd_sel_i   = 4'hF;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        chk("rstbus_cyc_up", 32'(bus.wbm_cyc_o), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rstbus_cyc", 32'(bus.wbm_cyc_o), 0);
        chk("rstbus_stb", 32'(bus.wbm_stb_o), 0);
        chk("rstbus_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("rstbus_adr", bus.wbm_adr_o, 0);
        slv_stray = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stray_rsp_valid", 32'(bus.rsp_valid_o), 0);
            chk("stray_cyc", 32'(bus.wbm_cyc_o), 0);
        end
        slv_stray = 1'b0;
        chk("stray_cmd_ready", 32'(bus.cmd_ready_o), 1);
        issue(1'b0, 32'h3000_0034, 32'h0, 4'hF, 1, 1'b0, 32'h0000_1234, 2, 32'h0000_1234, 1'b0);
        finish(1);

        // Random mix, including waits past the timeout window.
        for (int i = 0; i < 8; i++) begin
            we   = 1'($urandom_range(0, 1));
            wt   = $urandom_range(0, TO + 2);
            rd   = $urandom;
            eto  = (wt > TO);
            len  = eto ? TO + 1 : wt + 1;
            edat = (eto || we) ? 32'h0 : rd;
            issue(we, $urandom, $urandom, 4'($urandom_range(0, 15)), wt, 1'b0, rd, len, edat, eto);
            finish($urandom_range(0, 2));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", 32'(xq.size() + rq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
